pix_window_ctrl: RTL and testbench

Sequencing controller for the 8-bit horizontal tap shift register in the image front end. It accepts a raster pixel stream over a valid/ready handshake and drives the register's load/data inputs. It tracks which pixel sits at the centre of the three-pixel tap window and flags windows that lie fully inside an image row. At end of frame it flushes the register so the last window of the frame is emitted, then signals frame completion.

---
 rtl/pix_pkg.sv | 15 +
 rtl/raster_counter.sv | 39 +++
 rtl/pix_window_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pix_window_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared constants and state encoding for the pixel window controller.
package pix_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned TAP_LAG     = 4;
    localparam int unsigned FLUSH_LOADS = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with synchronous clear, enable, wrap and last-pixel flag.
module raster_counter #(
    parameter int unsigned W     = 640,
    parameter int unsigned H     = 480,
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(H - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/pix_window_ctrl.sv
// Tap shift register sequencer: pixel intake, end-of-frame flush, in-row window flagging.
// Define WIN_COORD_EN to build the centre row/column coordinate outputs.
module pix_window_ctrl
    import pix_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             stall,
    output logic             sr_load,
    output logic [PIX_W-1:0] sr_data,
    output logic             win_valid,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IMG_W - 1);
    localparam logic [2:0]       LAG_FULL  = 3'(TAP_LAG);
    localparam logic [1:0]       FLUSH_END = 2'(FLUSH_LOADS - 1);

    state_t state, state_nxt;

    logic             idle;
    logic             in_xfer;
    logic [COL_W-1:0] in_col;
    logic [ROW_W-1:0] in_row;
    logic             in_last;
    logic [1:0]       flush_cnt;
    logic [2:0]       lag_cnt;
    logic             primed;
    logic             c_adv;
    logic [COL_W-1:0] c_col;
    logic             c_last;
    logic             win_hit;

    assign idle    = (state == IDLE);
    assign busy    = !idle;
    assign in_xfer = (state == RUN) && sr_load;
    assign primed  = (lag_cnt == LAG_FULL);
    assign c_adv   = sr_load && primed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        sr_load    = 1'b0;
        sr_data    = '0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && !stall) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                pix_ready = !stall;
                sr_load   = pix_valid && !stall;
                sr_data   = pix_data;
                if (sr_load && in_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                sr_load = !stall;
                if (!stall && (flush_cnt == FLUSH_END)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counts loads until the centre tap (P2) holds pixel 0 of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lag_cnt   <= '0;
            flush_cnt <= '0;
        end else if (idle) begin
            lag_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (sr_load && !primed) begin
                lag_cnt <= lag_cnt + 1'b1;
            end
            if ((state == FLUSH) && sr_load) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    raster_counter #(
        .W    (IMG_W),
        .H    (IMG_H),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_in_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (idle),
        .en   (in_xfer),
        .col  (in_col),
        .row  (in_row),
        .last (in_last)
    );

`ifdef WIN_COORD_EN
    logic [ROW_W-1:0] c_row;

    raster_counter #(
        .W    (IMG_W),
        .H    (IMG_H),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_centre_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (idle),
        .en   (c_adv),
        .col  (c_col),
        .row  (c_row),
        .last (c_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_col <= '0;
            win_row <= '0;
        end else if (sr_load) begin
            win_col <= c_col;
            win_row <= c_row;
        end
    end
`else
    // Single-row counter: tracks only the centre column; its last flag is col == IMG_W-1.
    logic c_row_unused;

    raster_counter #(
        .W    (IMG_W),
        .H    (1),
        .COL_W(COL_W),
        .ROW_W(1)
    ) u_centre_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (idle),
        .en   (c_adv),
        .col  (c_col),
        .row  (c_row_unused),
        .last (c_last)
    );

    assign win_col = '0;
    assign win_row = '0;
`endif

    assign win_hit = primed && (c_col != '0) && (c_col != COL_MAX) && !c_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
        end else begin
            win_valid <= sr_load && win_hit;
        end
    end

endmodule

// File: tb/tb_pix_window_ctrl.sv
// Scoreboard bench for pix_window_ctrl on an 8x4 frame with a model tap shift register.
module tb_pix_window_ctrl;
    import pix_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int N     = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       stall;
    logic       sr_load;
    logic [7:0] sr_data;
    logic       win_valid;
    logic [2:0] win_col;
    logic [1:0] win_row;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int frame_pulses = 0;
    int done_count = 0;
    int flush_loads = 0;
    bit done_due = 0;
    logic [7:0] sr [0:5];

    pix_window_ctrl #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .COL_W(3),
        .ROW_W(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .stall      (stall),
        .sr_load    (sr_load),
        .sr_data    (sr_data),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Model of the tap shift register: P3 = sr[3], P2 = sr[4], P1 = sr[5].
    always @(posedge clk) begin
        if (sr_load) begin
            sr[0] <= sr_data;
            for (int i = 1; i < 6; i++) sr[i] <= sr[i-1];
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_zero(input string name);
        logic [21:0] v;
        v = {pix_ready, sr_load, sr_data, win_valid, win_col, win_row, busy, frame_done};
        chk(v == '0, name, longint'(v), 0);
    endtask

    // Monitor: pops the expected centre index on every window and checks frame_done timing.
    always @(negedge clk) begin
        if (reset) begin
            flush_loads = 0;
            done_due = 0;
        end else begin
            if (stall) chk(!sr_load, "stall_load", sr_load, 0);
            if (done_due) chk(frame_done, "done_timing", frame_done, 1);
            else if (frame_done) chk(0, "done_early", frame_done, 0);
            done_due = 0;
            if (frame_done) begin
                done_count++;
                flush_loads = 0;
            end
            if (sr_load && !pix_ready) begin
                flush_loads++;
                if (flush_loads == 3) done_due = 1;
            end
            if (win_valid) begin
                frame_pulses++;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_window", longint'(sr[4]), -1);
                end else begin
                    int c;
                    logic [23:0] taps_exp;
                    logic [4:0]  coord_exp;
                    c = exp_q.pop_front();
                    taps_exp = {8'(c - 1), 8'(c), 8'(c + 1)};
                    chk({sr[5], sr[4], sr[3]} == taps_exp, "window_taps",
                        longint'({sr[5], sr[4], sr[3]}), longint'(taps_exp));
`ifdef WIN_COORD_EN
                    coord_exp = {3'(c % IMG_W), 2'(c / IMG_W)};
`else
                    coord_exp = '0;
`endif
                    chk({win_col, win_row} == coord_exp, "window_coord",
                        longint'({win_col, win_row}), longint'(coord_exp));
                end
            end
        end
    end

    task automatic run_frame(input int mode, input int rst_at);
        int  idx = 0;
        int  cyc = 0;
        int  base_done;
        bit  fire;
        base_done = done_count;
        frame_pulses = 0;
        for (int c = 0; c < N; c++) begin
            if ((c % IMG_W != 0) && (c % IMG_W != IMG_W - 1) && (c <= N - 2)) exp_q.push_back(c);
        end
        frame_start = 1'b1;
        stall = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        while (idx < N && cyc < 2000) begin
            stall = (mode == 1) && ((cyc % 7 == 3) || (cyc % 11 == 5));
            pix_valid = !((mode == 1) && (cyc % 5 == 1));
            pix_data = 8'(idx);
            frame_start = (cyc == 10);
            if (rst_at >= 0 && idx == rst_at) begin
                reset = 1'b1;
                #1;
                check_zero("reset_mid_frame");
                exp_q.delete();
                frame_start = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b0;
                pix_valid = 1'b0;
                stall = 1'b0;
                return;
            end
            #1;
            fire = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            cyc++;
        end
        frame_start = 1'b0;
        pix_valid = 1'b0;
        if (idx < N) chk(0, "intake_timeout", idx, N);
        while (done_count == base_done && cyc < 3000) begin
            stall = (mode == 1) && (cyc % 3 == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        stall = 1'b0;
        chk(done_count != base_done, "frame_done_seen", done_count - base_done, 1);
        chk(frame_pulses == 24, "window_count", frame_pulses, 24);
        chk(exp_q.size() == 0, "windows_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("idle_after_reset");
        run_frame(0, -1);
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(0, 13);
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle_after_mid_reset");
        run_frame(0, -1);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
